wb_queue: RTL and testbench

- Write-back queue that drives the register-file write port (RegWre / WriteReg / WriteData).
- Buffers register results from multi-cycle producers (loads, mul/div) and writes them in order, one per cycle, whenever the pipeline grants the port.
- Reports pending-write hazards for the two read addresses ReadReg1 / ReadReg2, with optional data forwarding.

---
 rtl/wb_defs_pkg.sv | 13 +
 rtl/wb_match.sv | 32 +++
 rtl/wb_queue.sv | 135 +++++++++++++
 tb/tb_wb_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_defs_pkg.sv
// Shared defaults and entry layout for the write-back queue.
// Package name is wb_defs; entries are packed as {reg, data}, reg in the upper bits.
package wb_defs;
    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic [REG_W_DEF-1:0]  rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// Searches the queued entries for a destination-register match.
// Walks the entries oldest to youngest so the youngest match's data wins.
module wb_match #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic [DEPTH-1:0][REG_W+DATA_W-1:0] entries_i,
    input  logic [DEPTH-1:0]                   valid_i,
    input  logic [$clog2(DEPTH)-1:0]           rptr_i,
    input  logic [REG_W-1:0]                   rd_addr_i,
    output logic                               hit_o,
    output logic [DATA_W-1:0]                  data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = REG_W + DATA_W;

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_i + PTR_W'(i);
            if (valid_i[idx] && (entries_i[idx][ENT_W-1 -: REG_W] == rd_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx][DATA_W-1:0];
            end
        end
    end
endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the register-file write port, with pending-write hazard flags.
// Define WB_FORWARD_EN to add FwdData1/FwdData2 carrying the youngest pending data.
module wb_queue
    import wb_defs::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [REG_W-1:0]         InReg,
    input  logic [DATA_W-1:0]        InData,
    input  logic                     RfGrant,
    output logic                     RegWre,
    output logic [REG_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [REG_W-1:0]         ReadReg1,
    input  logic [REG_W-1:0]         ReadReg2,
    output logic                     Busy1,
    output logic                     Busy2,
`ifdef WB_FORWARD_EN
    output logic [DATA_W-1:0]        FwdData1,
    output logic [DATA_W-1:0]        FwdData2,
`endif
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = REG_W + DATA_W;

    logic [DEPTH-1:0][ENT_W-1:0] mem_q;
    logic [PTR_W-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        regwre_q, regwre_d;
    logic [REG_W-1:0]            wreg_q, wreg_d;
    logic [DATA_W-1:0]           wdata_q, wdata_d;
    logic                        accept, push, pop;
    logic [DEPTH-1:0]            valid;
    logic [PTR_W-1:0]            off;
    logic                        qhit1, qhit2;
    logic [DATA_W-1:0]           qdata1, qdata2;

    assign InReady = (count_q != CNT_W'(DEPTH));
    assign accept  = InValid && InReady;
    // Writes to r0 complete the handshake but are dropped here.
    assign push    = accept && (InReg != REG_W'(REG_ZERO));
    assign pop     = RfGrant && (count_q != '0);

    always_comb begin
        wptr_d   = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d   = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
        regwre_d = pop;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        if (pop) begin
            wreg_d  = mem_q[rptr_q][ENT_W-1 -: REG_W];
            wdata_d = mem_q[rptr_q][DATA_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            regwre_q <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            regwre_q <= regwre_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset && push)
            mem_q[wptr_q] <= {InReg, InData};
    end

    always_comb begin
        valid = '0;
        off   = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off      = PTR_W'(j) - rptr_q;
            valid[j] = ({1'b0, off} < count_q);
        end
    end

    wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) u_match1 (
        .entries_i (mem_q),
        .valid_i   (valid),
        .rptr_i    (rptr_q),
        .rd_addr_i (ReadReg1),
        .hit_o     (qhit1),
        .data_o    (qdata1)
    );

    wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) u_match2 (
        .entries_i (mem_q),
        .valid_i   (valid),
        .rptr_i    (rptr_q),
        .rd_addr_i (ReadReg2),
        .hit_o     (qhit2),
        .data_o    (qdata2)
    );

    assign Busy1 = (ReadReg1 != REG_W'(REG_ZERO)) && (qhit1 || (regwre_q && wreg_q == ReadReg1));
    assign Busy2 = (ReadReg2 != REG_W'(REG_ZERO)) && (qhit2 || (regwre_q && wreg_q == ReadReg2));

`ifdef WB_FORWARD_EN
    // Queue entries are younger than the output stage, so they take priority.
    assign FwdData1 = !Busy1 ? '0 : (qhit1 ? qdata1 : wdata_q);
    assign FwdData2 = !Busy2 ? '0 : (qhit2 ? qdata2 : wdata_q);
`else
    logic unused_fwd;
    assign unused_fwd = ^{qdata1, qdata2};
`endif

    assign RegWre    = regwre_q;
    assign WriteReg  = wreg_q;
    assign WriteData = wdata_q;
    assign Count     = count_q;
endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue; forwarding checks run only when WB_FORWARD_EN is defined.
module tb_wb_queue;
    logic        CLK = 1'b0;
    logic        Reset, InValid, RfGrant;
    logic        InReady, RegWre, Busy1, Busy2;
    logic [4:0]  InReg, WriteReg, ReadReg1, ReadReg2;
    logic [31:0] InData, WriteData;
    logic [2:0]  Count;
`ifdef WB_FORWARD_EN
    logic [31:0] FwdData1, FwdData2;
`endif
    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    wb_queue dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InReg     (InReg),
        .InData    (InData),
        .RfGrant   (RfGrant),
        .RegWre    (RegWre),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .Busy1     (Busy1),
        .Busy2     (Busy2),
`ifdef WB_FORWARD_EN
        .FwdData1  (FwdData1),
        .FwdData2  (FwdData2),
`endif
        .Count     (Count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_drive(input logic [4:0] r, input logic [31:0] d);
        InValid = 1'b1;
        InReg   = r;
        InData  = d;
        step();
    endtask

    initial begin
        Reset = 1'b0; InValid = 1'b0; RfGrant = 1'b0;
        InReg = '0; InData = '0; ReadReg1 = '0; ReadReg2 = '0;
        step();
        chk("por_count", 64'(Count), 64'd0);
        chk("por_regwre", 64'(RegWre), 64'd0);
        chk("por_inready", 64'(InReady), 64'd1);
        Reset = 1'b1;

        // reset mid-operation
        ReadReg1 = 5'd4; ReadReg2 = 5'd5;
        push_drive(5'd3, 32'h33);
        push_drive(5'd4, 32'h44);
        push_drive(5'd5, 32'h55);
        InValid = 1'b0;
        #1;
        chk("fill3_count", 64'(Count), 64'd3);
        chk("fill3_busy1", 64'(Busy1), 64'd1);
        Reset = 1'b0;
        step();
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_regwre", 64'(RegWre), 64'd0);
        chk("rst_writereg", 64'(WriteReg), 64'd0);
        chk("rst_inready", 64'(InReady), 64'd1);
        chk("rst_busy1", 64'(Busy1), 64'd0);
        chk("rst_busy2", 64'(Busy2), 64'd0);
        Reset = 1'b1;
        RfGrant = 1'b1;
        step();
        chk("rst_no_drain", 64'(RegWre), 64'd0);

        // single write
        ReadReg1 = 5'd8; ReadReg2 = 5'd0;
        #1;
        chk("single_busy_pre", 64'(Busy1), 64'd0);
        push_drive(5'd8, 32'hDEADBEEF);
        InValid = 1'b0;
        #1;
        chk("single_count1", 64'(Count), 64'd1);
        chk("single_regwre0", 64'(RegWre), 64'd0);
        chk("single_busy_q", 64'(Busy1), 64'd1);
        step();
        chk("single_regwre", 64'(RegWre), 64'd1);
        chk("single_wreg", 64'(WriteReg), 64'd8);
        chk("single_wdata", 64'(WriteData), 64'hDEADBEEF);
        chk("single_busy_out", 64'(Busy1), 64'd1);
        chk("single_count0", 64'(Count), 64'd0);
        step();
        chk("single_regwre_drop", 64'(RegWre), 64'd0);
        chk("single_busy_drop", 64'(Busy1), 64'd0);
        chk("single_wreg_hold", 64'(WriteReg), 64'd8);

        // full and stall
        RfGrant = 1'b0;
        push_drive(5'd10, 32'hA0);
        push_drive(5'd11, 32'hA1);
        push_drive(5'd12, 32'hA2);
        chk("full_ready3", 64'(InReady), 64'd1);
        push_drive(5'd13, 32'hA3);
        chk("full_count", 64'(Count), 64'd4);
        chk("full_inready", 64'(InReady), 64'd0);
        push_drive(5'd14, 32'hA4);
        chk("full_reject", 64'(Count), 64'd4);
        InValid = 1'b0;
        RfGrant = 1'b1;
        ReadReg2 = 5'd14;
        #1;
        chk("full_busy_rejected", 64'(Busy2), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_regwre", 64'(RegWre), 64'd1);
            chk("drain_wreg", 64'(WriteReg), 64'(10 + k));
            chk("drain_wdata", 64'(WriteData), 64'(32'hA0 + k));
            chk("drain_count", 64'(Count), 64'(3 - k));
            chk("drain_inready", 64'(InReady), 64'd1);
        end
        step();
        chk("drain_idle", 64'(RegWre), 64'd0);

        // register 0 discard
        ReadReg1 = 5'd0;
        InValid = 1'b1; InReg = 5'd0; InData = 32'd5;
        #1;
        chk("r0_inready", 64'(InReady), 64'd1);
        step();
        InValid = 1'b0;
        chk("r0_count", 64'(Count), 64'd0);
        chk("r0_busy1", 64'(Busy1), 64'd0);
        step();
        chk("r0_regwre_a", 64'(RegWre), 64'd0);
        step();
        chk("r0_regwre_b", 64'(RegWre), 64'd0);

        // same register twice
        RfGrant = 1'b0;
        ReadReg1 = 5'd9;
        push_drive(5'd9, 32'd1);
        push_drive(5'd9, 32'd2);
        InValid = 1'b0;
        #1;
        chk("same_count", 64'(Count), 64'd2);
        chk("same_busy1", 64'(Busy1), 64'd1);
`ifdef WB_FORWARD_EN
        chk("same_fwd_young", 64'(FwdData1), 64'd2);
`endif
        RfGrant = 1'b1;
        step();
        chk("same_first_reg", 64'(WriteReg), 64'd9);
        chk("same_first_data", 64'(WriteData), 64'd1);
`ifdef WB_FORWARD_EN
        chk("same_fwd_queue", 64'(FwdData1), 64'd2);
`endif
        step();
        chk("same_second_data", 64'(WriteData), 64'd2);
        chk("same_second_we", 64'(RegWre), 64'd1);
`ifdef WB_FORWARD_EN
        chk("same_fwd_out", 64'(FwdData1), 64'd2);
`endif
        step();
        chk("same_idle_busy", 64'(Busy1), 64'd0);

        // simultaneous push and pop
        RfGrant = 1'b0;
        push_drive(5'd20, 32'h14);
        push_drive(5'd21, 32'h15);
        chk("sim_pre_count", 64'(Count), 64'd2);
        InReg = 5'd22; InData = 32'h16; RfGrant = 1'b1;
        step();
        InValid = 1'b0;
        chk("sim_count", 64'(Count), 64'd2);
        chk("sim_regwre", 64'(RegWre), 64'd1);
        chk("sim_head_reg", 64'(WriteReg), 64'd20);
        chk("sim_head_data", 64'(WriteData), 64'h14);
        step();
        chk("sim_mid_reg", 64'(WriteReg), 64'd21);
        chk("sim_mid_data", 64'(WriteData), 64'h15);
        step();
        chk("sim_tail_reg", 64'(WriteReg), 64'd22);
        chk("sim_tail_data", 64'(WriteData), 64'h16);
        chk("sim_final_count", 64'(Count), 64'd0);
        step();
        chk("sim_idle", 64'(RegWre), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
